seq_divider: RTL and testbench

Sequential unsigned integer divider using a restoring shift-subtract algorithm. It is the inverse datapath companion to the team's start/valid repeated-addition multiplier, with the same start-pulse/valid-flag handshake style. Operands are captured on start. Quotient and remainder are produced after a fixed WIDTH-cycle iteration, and divide-by-zero is flagged early. It sits beside the multiplier in the arithmetic unit, and software/FSM layers use the two interchangeably.

---
 rtl/seq_divider.sv | 147 ++++++++++++++
 tb/tb_seq_divider.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider
// Sequential unsigned divider using the restoring shift-subtract method.
// It uses a start/valid handshake: a start pulse captures the operands, and
// WIDTH edges later a one-cycle valid strobe presents the quotient and
// remainder. Divide-by-zero is reported at the accepting edge, with no
// iteration.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   in1          dividend, sampled on an accepted start
//   in2          divisor, sampled on an accepted start
//   S            start request, level-sampled each edge (ignored while busy)
//   busy         high from the accepted start until the result edge
//   V            one-cycle result-valid strobe
//   quotient     registered quotient, held until the next result
//   remainder    registered remainder, held until the next result
//   div_by_zero  set with V when the divisor was zero, held with results
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             S,
  output logic             busy,
  output logic             V,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] dividend, dividend_next;
  logic [WIDTH-1:0] divisor, divisor_next;
  logic [WIDTH-1:0] work_q, work_q_next;
  logic [WIDTH:0]   partial, partial_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] quotient_next, remainder_next;
  logic             dbz_next, v_next;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH:0]   new_partial;
  logic [WIDTH-1:0] new_q;

  // The partial remainder is always below the divisor, so it fits in WIDTH
  // bits. After the shift it can need WIDTH+1 bits. The trial subtraction
  // is done at WIDTH+1 bits, so its top bit is the sign: zero means the
  // divisor fits.
  assign shifted     = (partial << 1) | {{WIDTH{1'b0}}, dividend[WIDTH-1]};
  assign trial       = shifted - {1'b0, divisor};
  assign q_bit       = ~trial[WIDTH];
  assign new_partial = q_bit ? trial : shifted;
  assign new_q       = (work_q << 1) | {{(WIDTH-1){1'b0}}, q_bit};

  assign busy = (state == RUN);

  // State and datapath registers. Reset discards any operation in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dividend    <= '0;
      divisor     <= '0;
      work_q      <= '0;
      partial     <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      V           <= 1'b0;
    end else begin
      state       <= state_next;
      dividend    <= dividend_next;
      divisor     <= divisor_next;
      work_q      <= work_q_next;
      partial     <= partial_next;
      count       <= count_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
      div_by_zero <= dbz_next;
      V           <= v_next;
    end
  end

  // Next-state and datapath logic. By default everything holds and V drops.
  // Output registers change only on a result edge.
  always_comb begin
    state_next     = state;
    dividend_next  = dividend;
    divisor_next   = divisor;
    work_q_next    = work_q;
    partial_next   = partial;
    count_next     = count;
    quotient_next  = quotient;
    remainder_next = remainder;
    dbz_next       = div_by_zero;
    v_next         = 1'b0;

    case (state)
      IDLE: begin
        if (S) begin
          if (in2 != '0) begin
            dividend_next = in1;
            divisor_next  = in2;
            work_q_next   = '0;
            partial_next  = '0;
            count_next    = CW'(WIDTH);
            state_next    = RUN;
          end else begin
            // A zero divisor is resolved immediately, with no iteration.
            quotient_next  = '1;
            remainder_next = in1;
            dbz_next       = 1'b1;
            v_next         = 1'b1;
          end
        end
      end

      RUN: begin
        dividend_next = dividend << 1;
        partial_next  = new_partial;
        work_q_next   = new_q;
        count_next    = count - CW'(1);
        if (count == CW'(1)) begin
          quotient_next  = new_q;
          remainder_next = new_partial[WIDTH-1:0];
          dbz_next       = 1'b0;
          v_next         = 1'b1;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
// Self-checking bench for seq_divider with WIDTH=32. The bench uses a table
// of directed vectors and hand-written sequences for the start-while-busy,
// reset and back-to-back cases. It then checks random operands against a
// plain-arithmetic model (n/d, n%d).
module tb_seq_divider;

  logic        clock;
  logic        reset_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        S;
  logic        busy;
  logic        V;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int pass_count  = 0;
  int total_count = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in1         (in1),
    .in2         (in2),
    .S           (S),
    .busy        (busy),
    .V           (V),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Guards against a hung run.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    int          busy_cycles;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Drives one start pulse. Returns at the falling edge after the
  // accepting edge, with operands scrambled.
  task automatic applyStimulus(input logic [31:0] n, input logic [31:0] d);
    @(negedge clock);
    in1 = n; in2 = d; S = 1'b1;
    @(negedge clock);
    S = 1'b0; in1 = $urandom; in2 = $urandom;
  endtask

  // Counts edges after the accepting edge until V is seen.
  // A timeout returns lat >= 100.
  task automatic waitResult(input int start_lat, output int lat, output int busy_cycles);
    lat = start_lat; busy_cycles = 0;
    while (!V && lat < 100) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      lat++;
    end
  endtask

  logic [31:0] bn [0:101];
  logic [31:0] bd [0:101];

  initial begin
    int lat, bcy, vcount;
    logic [31:0] n, d, held_q;
    logic [63:0] recon;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 32, 32};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 32, 32};
    vecs[2] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 32, 32};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 32, 32};
    vecs[4] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 0,  0};
    vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 32, 32};
    vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 32, 32};
    vecs[7] = '{32'd1000,       32'd0,          32'hFFFF_FFFF,  32'd1000,       1'b1, 0,  0};

    // Reset state
    reset_n = 1'b0; S = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_V", V, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_dbz", div_by_zero, 0);
    reset_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].n, vecs[i].d);
      waitResult(0, lat, bcy);
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d_busy_cycles", i), bcy, vecs[i].busy_cycles);
      checkOutput($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      checkOutput($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      checkOutput($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].dbz);
      held_q = quotient;
      @(negedge clock);
      checkOutput($sformatf("vec%0d_V_strobe", i), V, 0);
      checkOutput($sformatf("vec%0d_busy_after", i), busy, 0);
      repeat (3) @(negedge clock);
      checkOutput($sformatf("vec%0d_quotient_hold", i), quotient, held_q);
    end

    // Start held while busy is ignored
    @(negedge clock);
    in1 = 32'd1000; in2 = 32'd3; S = 1'b1;
    @(negedge clock);
    in1 = 32'd9; in2 = 32'd9;
    repeat (10) @(negedge clock);
    S = 1'b0;
    waitResult(10, lat, bcy);
    checkOutput("hold_latency", lat, 32);
    checkOutput("hold_quotient", quotient, 333);
    checkOutput("hold_remainder", remainder, 1);
    @(negedge clock);
    checkOutput("hold_V_single", V, 0);
    checkOutput("hold_no_restart", busy, 0);

    // Reset in the middle of an operation
    applyStimulus(32'd50, 32'd5);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_V", V, 0);
    checkOutput("midrst_quotient", quotient, 0);
    checkOutput("midrst_remainder", remainder, 0);
    checkOutput("midrst_dbz", div_by_zero, 0);
    @(negedge clock);
    reset_n = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(negedge clock);
      if (V) vcount++;
    end
    checkOutput("midrst_no_V", vcount, 0);
    applyStimulus(32'd50, 32'd5);
    waitResult(0, lat, bcy);
    checkOutput("midrst_fresh_latency", lat, 32);
    checkOutput("midrst_fresh_quotient", quotient, 10);
    checkOutput("midrst_fresh_remainder", remainder, 0);

    // Back-to-back with S held high: operands accepted at edges 0, 33, 66, 99
    for (int i = 0; i < 102; i++) begin
      bn[i] = $urandom;
      bd[i] = $urandom >> $urandom_range(0, 28);
      if (bd[i] == 0) bd[i] = 32'd1;
    end
    @(negedge clock);
    in1 = bn[0]; in2 = bd[0]; S = 1'b1;
    for (int e = 0; e <= 100; e++) begin
      @(negedge clock);
      checkOutput($sformatf("b2b_V_edge%0d", e), V, (e % 33) == 32);
      if ((e % 33) == 32) begin
        checkOutput($sformatf("b2b_q_edge%0d", e), quotient,
                    bn[(e / 33) * 33] / bd[(e / 33) * 33]);
        checkOutput($sformatf("b2b_r_edge%0d", e), remainder,
                    bn[(e / 33) * 33] % bd[(e / 33) * 33]);
      end
      in1 = bn[e + 1]; in2 = bd[e + 1];
    end
    S = 1'b0;
    repeat (40) @(negedge clock);

    // Random operands against the arithmetic model
    for (int k = 0; k < 1000; k++) begin
      n = $urandom;
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = $urandom_range(0, 255);
        2: d = $urandom >> $urandom_range(0, 31);
        default: begin n = $urandom_range(0, 1000); d = $urandom; end
      endcase
      applyStimulus(n, d);
      waitResult(0, lat, bcy);
      if (d == 0) begin
        checkOutput($sformatf("rnd%0d_dbz_latency", k), lat, 0);
        checkOutput($sformatf("rnd%0d_dbz_flag", k), div_by_zero, 1);
        checkOutput($sformatf("rnd%0d_dbz_q", k), quotient, 32'hFFFF_FFFF);
        checkOutput($sformatf("rnd%0d_dbz_r", k), remainder, n);
      end else begin
        recon = 64'(quotient) * 64'(d) + 64'(remainder);
        checkOutput($sformatf("rnd%0d_latency", k), lat, 32);
        checkOutput($sformatf("rnd%0d_reconstruct", k), recon, 64'(n));
        checkOutput($sformatf("rnd%0d_r_lt_d", k), remainder < d, 1);
        checkOutput($sformatf("rnd%0d_quotient", k), quotient, n / d);
        checkOutput($sformatf("rnd%0d_dbz_clear", k), div_by_zero, 0);
      end
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
